// File: rtl/ldm_stm_sequencer_if.sv
// Request/beat bundle between decode, ldm_stm_sequencer and the LSU.
// LDM_STM_ABORT_EN adds the i_abort / o_aborted pair.
interface ldm_stm_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              i_start;
  logic [15:0]       i_reg_list;
  logic [ADDR_W-1:0] i_base_addr;
  logic              i_up;
  logic              i_pre;
  logic              i_ready;
  logic              o_busy;
  logic              o_valid;
  logic [3:0]        o_reg_index;
  logic [ADDR_W-1:0] o_addr;
  logic              o_last;
  logic              o_done;
  logic [ADDR_W-1:0] o_wb_addr;
`ifdef LDM_STM_ABORT_EN
  logic              i_abort;
  logic              o_aborted;
`endif

  modport master (
    input  i_start, i_reg_list, i_base_addr,
    input  i_up, i_pre, i_ready,
`ifdef LDM_STM_ABORT_EN
    input  i_abort,
    output o_aborted,
`endif
    output o_busy, o_valid, o_reg_index,
    output o_addr, o_last, o_done, o_wb_addr
  );

  modport slave (
    output i_start, i_reg_list, i_base_addr,
    output i_up, i_pre, i_ready,
`ifdef LDM_STM_ABORT_EN
    output i_abort,
    input  o_aborted,
`endif
    input  o_busy, o_valid, o_reg_index,
    input  o_addr, o_last, o_done, o_wb_addr
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM beat sequencer: one (reg, addr) beat per set list bit.
// Optional abort support is enabled by defining LDM_STM_ABORT_EN.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32
) (
  input logic               i_clk,
  input logic               i_rst_n,
  ldm_stm_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, CALC, XFER, DONE
  } state_t;

  state_t            state;
  logic [15:0]       list_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] wb_q;
  logic              up_q;
  logic              pre_q;

  function automatic logic [3:0] low_idx(
    input logic [15:0] l
  );
    low_idx = '0;
    for (int k = 15; k >= 0; k--)
      if (l[k]) low_idx = 4'(k);
  endfunction

  function automatic logic [4:0] pop(
    input logic [15:0] l
  );
    pop = '0;
    for (int k = 0; k < 16; k++)
      pop = pop + {4'b0, l[k]};
  endfunction

  logic [4:0]        n;
  logic [ADDR_W-1:0] n4;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] wb_addr;
  logic [15:0]       rem;
  logic              hs;
  logic              abort;

  always_comb begin
    n  = pop(list_q);
    n4 = ADDR_W'({n, 2'b00});
    start_addr = base_q;
    unique case ({up_q, pre_q})
      2'b10: start_addr = base_q;
      2'b11: start_addr = base_q + ADDR_W'(4);
      2'b00: start_addr = base_q - n4 + ADDR_W'(4);
      2'b01: start_addr = base_q - n4;
      default: start_addr = base_q;
    endcase
    wb_addr = up_q ? base_q + n4 : base_q - n4;
    rem = list_q & ~(16'b1 << bus.o_reg_index);
    hs  = bus.o_valid & bus.i_ready;
  end

`ifdef LDM_STM_ABORT_EN
  assign abort = bus.i_abort;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      list_q          <= '0;
      base_q          <= '0;
      wb_q            <= '0;
      up_q            <= 1'b0;
      pre_q           <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_valid     <= 1'b0;
      bus.o_reg_index <= '0;
      bus.o_addr      <= '0;
      bus.o_last      <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_wb_addr   <= '0;
`ifdef LDM_STM_ABORT_EN
      bus.o_aborted   <= 1'b0;
`endif
    end else begin
      bus.o_done <= 1'b0;
`ifdef LDM_STM_ABORT_EN
      bus.o_aborted <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (bus.i_start) begin
            list_q     <= bus.i_reg_list;
            base_q     <= bus.i_base_addr;
            up_q       <= bus.i_up;
            pre_q      <= bus.i_pre;
            bus.o_busy <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            bus.o_busy <= 1'b0;
            state      <= IDLE;
`ifdef LDM_STM_ABORT_EN
            bus.o_aborted <= 1'b1;
`endif
          end else if (n == 5'd0) begin
            bus.o_done    <= 1'b1;
            bus.o_wb_addr <= base_q;
            state         <= DONE;
          end else begin
            wb_q            <= wb_addr;
            bus.o_valid     <= 1'b1;
            bus.o_reg_index <= low_idx(list_q);
            bus.o_addr      <= start_addr;
            bus.o_last      <= (n == 5'd1);
            state           <= XFER;
          end
        end
        XFER: begin
          // Abort wins over a same-cycle handshake.
          if (abort) begin
            bus.o_valid <= 1'b0;
            bus.o_last  <= 1'b0;
            bus.o_busy  <= 1'b0;
            state       <= IDLE;
`ifdef LDM_STM_ABORT_EN
            bus.o_aborted <= 1'b1;
`endif
          end else if (hs) begin
            list_q <= rem;
            if (bus.o_last) begin
              bus.o_valid   <= 1'b0;
              bus.o_last    <= 1'b0;
              bus.o_done    <= 1'b1;
              bus.o_wb_addr <= wb_q;
              state         <= DONE;
            end else begin
              bus.o_reg_index <= low_idx(rem);
              bus.o_addr      <= bus.o_addr + ADDR_W'(4);
              bus.o_last      <= (pop(rem) == 5'd1);
            end
          end
        end
        DONE: begin
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Drives block data transfers (LDM/STM) from a 16-bit register list.
- Per accepted request, emits one (register index, word address) beat per set list bit, in ascending register order. Each beat uses a valid/ready handshake.
- Computes the base writeback value.
- Sits between the decode stage and the load/store unit; the load/store unit consumes the beats.

Parameters:
- ADDR_W, 32, address width. Address arithmetic wraps modulo 2^ADDR_W.

Ports:
- i_clk  input  1  clock; one clock domain.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_start  input  1  request strobe; sampled only in IDLE.
- i_reg_list  input  16  register list; bit k set means transfer Rk.
- i_base_addr  input  ADDR_W  base register value.
- i_up  input  1  U bit: 1 = increment, 0 = decrement.
- i_pre  input  1  P bit: 1 = before, 0 = after.
- i_ready  input  1  consumer accepts the current beat.
- o_busy  output  1  high in every state except IDLE.
- o_valid  output  1  beat valid.
- o_reg_index  output  4  register index of the current beat.
- o_addr  output  ADDR_W  word address of the current beat.
- o_last  output  1  current beat is the final beat.
- o_done  output  1  one-cycle pulse when the sequence completes.
- o_wb_addr  output  ADDR_W  base writeback value; valid from o_done, held until next start.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0 (o_busy, o_valid, o_reg_index, o_addr, o_last, o_done, o_wb_addr); internal list copy 0.
- FSM states: IDLE, CALC, XFER, DONE.
- IDLE:
  - i_start=1 latches list, base, U, P; next state CALC.
  - i_start=0 stays in IDLE.
- CALC (exactly one cycle):
  - n = popcount(list), range 0..16.
  - Start address: IA = base; IB = base+4; DA = base-4n+4; DB = base-4n.
  - Writeback: up = base+4n; down = base-4n.
  - n=0: go to DONE with no beats; o_wb_addr = base.
  - Otherwise go to XFER.
- Latency: i_start in cycle T gives first o_valid in cycle T+2.
- XFER beats:
  - o_valid=1; o_reg_index = index of the lowest set bit of the remaining list; o_addr = current address; o_last=1 when exactly one bit remains.
  - o_reg_index, o_addr and o_last stay stable while o_valid=1 and i_ready=0.
- XFER handshake (o_valid & i_ready, at most one beat per cycle):
  - Clear that bit; address += 4 (ascending for all four modes).
  - If it was the last beat, go to DONE and drop o_valid the next cycle.
  - Otherwise the next beat is presented the next cycle, so back-to-back beats are possible.
- DONE: o_done=1 for one cycle, o_busy=1, o_wb_addr valid; next state IDLE.
- i_start while not in IDLE is ignored, not queued.
- i_ready while o_valid=0 is ignored.
- Input changes after the start cycle have no effect; all request fields are latched.
- Address wrap: ADDR_W-bit modulo arithmetic, no error flag.
- Reset asserted mid-sequence: immediate return to IDLE with reset values; no o_done.

Optional Feature:
- Macro: LDM_STM_ABORT_EN.
- Defined:
  - Adds input i_abort (1 bit) and output o_aborted (1 bit, reset 0).
  - i_abort=1 in CALC or XFER cancels the sequence. Abort has priority over a same-cycle handshake, and that beat does not count.
  - The next cycle is IDLE, with o_aborted=1 for one cycle, o_valid=0, no o_done, and o_wb_addr unchanged.
  - i_abort is ignored in IDLE and DONE.
- Undefined: neither port exists; a sequence always runs to DONE unless reset.

Test Plan:
- IA, list 0x8005, base 0x1000, i_ready=1:
  - Beats (0,0x1000), (2,0x1004), (15,0x1008); o_last only on the third beat.
  - o_done one cycle after the last beat; wb=0x100C; first o_valid 2 cycles after i_start.
- DB, list 0x00F0, base 0x2000: beats r4..r7 at 0x1FF0, 0x1FF4, 0x1FF8, 0x1FFC; wb=0x1FF0.
- IB, list 0x0003, base 0x100: beats (0,0x104), (1,0x108); wb=0x108.
- DA, list 0x0003, base 0x100: beats (0,0xFC), (1,0x100); wb=0xF8.
- Backpressure and ignored start:
  - IA list 0x0006; hold i_ready=0 for 3 cycles on each beat.
  - Each beat's outputs stay stable; exactly 2 beats; an i_start pulse mid-sequence is ignored.
- Boundaries:
  - Empty list, base 0x40: no o_valid; o_done at T+2; wb=0x40.
  - IA base 0xFFFFFFFC, list 0x0003: addresses 0xFFFFFFFC, 0x00000000; wb=0x00000004.
  - i_rst_n low during the second beat: all outputs 0 at once; no o_done.
  - If LDM_STM_ABORT_EN is defined: i_abort on the first beat gives one o_aborted pulse, no o_done, and a return to IDLE.
